// File: rtl/encoder_8_3_rr.sv
// encoder_8_3_rr
//
// Sequential 8-to-3 request encoder. Single-cycle request pulses on `req`
// are collected into a pending set; one 3-bit index per handshake is
// presented on {a,b,c} (a = MSB) for a downstream 3-to-8 decoder.
// Simultaneous requests are served round-robin (ROUND_ROBIN=1, search
// starts just after the last issued index) or by fixed priority
// (ROUND_ROBIN=0, lowest index first).
//
// Handshake: {a,b,c} is transferred on a rising edge where out_valid and
// out_ready are both high. While out_valid=1 and out_ready=0 the index and
// out_valid hold steady for as long as the consumer stalls. out_ready has
// no effect while out_valid=0.
//
// Ports:
//   clk        in   1  clock, all state updates on the rising edge
//   rst        in   1  synchronous active-high reset
//   req        in   8  request pulses, bit i requests index i
//   out_ready  in   1  consumer accepts the held index this cycle
//   out_valid  out  1  {a,b,c} holds a valid index
//   a, b, c    out  1  issued index bits 2, 1, 0
//   pending    out  8  accepted, not-yet-issued requests
//   overflow   out  1  sticky: a request hit an already pending bit

module encoder_8_3_rr #(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       out_ready,
    output logic       out_valid,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic [7:0] pending,
    output logic       overflow
);

    logic [2:0] last;       // last issued index, round-robin search origin
    logic [7:0] cand;       // requests eligible for selection this cycle
    logic       slot_free;  // output register may be loaded this edge
    logic       found;      // cand is non-empty
    logic [2:0] sel;        // selected index
    logic [2:0] idx;        // scan position

    assign cand      = pending | req;
    assign slot_free = !out_valid || out_ready;

    always_comb begin
        found = 1'b0;
        sel   = 3'd0;
        idx   = 3'd0;
        if (ROUND_ROBIN) begin
            // Scan last+1 .. last+8 modulo 8, so `last` itself is tried last.
            for (int k = 1; k <= 8; k++) begin
                idx = last + 3'(k);
                if (!found && cand[idx]) begin
                    found = 1'b1;
                    sel   = idx;
                end
            end
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (!found && cand[k]) begin
                    found = 1'b1;
                    sel   = 3'(k);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            {a, b, c} <= 3'b000;
            pending   <= 8'h00;
            overflow  <= 1'b0;
            last      <= 3'd7;  // first round-robin search starts at index 0
        end else begin
            // A request for the index sitting in the output register is not
            // pending, so it does not count as overflow here.
            overflow <= overflow | (|(req & pending));
            if (slot_free) begin
                if (found) begin
                    {a, b, c} <= sel;
                    out_valid <= 1'b1;
                    last      <= sel;
                    // A request selected in its arrival cycle never lands
                    // in pending.
                    pending   <= cand & ~(8'b1 << sel);
                end else begin
                    out_valid <= 1'b0;
                    pending   <= 8'h00;
                end
            end else begin
                pending <= cand;
            end
        end
    end

endmodule
